// File: rtl/dh_key_sequencer.sv
// dh_key_sequencer
// Runs Diffie-Hellman key jobs on an external modular-power engine. A GEN job
// computes pub_key = G^priv mod P and stores priv for later jobs. A PEER job
// computes shared_key = peer_pub^priv mod P. Requests wait in two one-deep
// slots. GEN always wins arbitration, so a GEN and a PEER requested in the
// same cycle run in that order. An engine that never answers is cut off by a
// watchdog on the WAIT state.
module dh_key_sequencer #(
  parameter int N       = 8,
  parameter int P       = 89,
  parameter int G       = 3,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         gen_req,
  input  logic [N-1:0] priv_key,
  input  logic         peer_req,
  input  logic [N-1:0] peer_pub,
  output logic         mp_start,
  output logic [N-1:0] mp_base,
  output logic [N-1:0] mp_exp,
  input  logic [N-1:0] mp_res,
  input  logic         mp_rdy,
  output logic [N-1:0] pub_key,
  output logic         pub_valid,
  output logic [N-1:0] shared_key,
  output logic         shared_valid,
  output logic         busy,
  output logic         err
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0]  P_VAL    = N'(P);
  localparam logic [N-1:0]  G_VAL    = N'(G);
  localparam logic [N-1:0]  TWO      = N'(2);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t        state_reg;

  // Pending request slots, one entry each.
  logic          gen_full_reg;
  logic [N-1:0]  gen_op_reg;
  logic          peer_full_reg;
  logic [N-1:0]  peer_op_reg;

  // Private key of the most recently launched GEN job.
  logic [N-1:0]  priv_reg;
  logic          priv_valid_reg;

  // Active job bookkeeping.
  logic          job_gen_reg;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  res_reg;

  // Request qualification and arbitration decisions for this cycle.
  logic          gen_key_ok;
  logic          gen_accept;
  logic          gen_reject;
  logic          peer_pub_ok;
  logic          peer_key_ok;
  logic          peer_accept;
  logic          peer_reject;
  logic          take_gen;
  logic          take_peer;
  logic          timeout_hit;

  // Decide which requests are accepted and which job (if any) starts now.
  always_comb begin
    gen_key_ok  = 1'b0;
    gen_accept  = 1'b0;
    gen_reject  = 1'b0;
    peer_pub_ok = 1'b0;
    peer_key_ok = 1'b0;
    peer_accept = 1'b0;
    peer_reject = 1'b0;
    take_gen    = 1'b0;
    take_peer   = 1'b0;
    timeout_hit = 1'b0;

    // The engine treats a signed exponent <= 0 as trivial, so only
    // strictly positive keys with a clear sign bit are usable.
    gen_key_ok  = (priv_key != '0) && !priv_key[N-1];
    gen_accept  = gen_req && !gen_full_reg && gen_key_ok;
    gen_reject  = gen_req && !gen_accept;

    // A peer key of 0 or 1 (or outside the field) gives a degenerate secret.
    peer_pub_ok = (peer_pub >= TWO) && (peer_pub < P_VAL);
    // A PEER job needs a key: either one already stored, or a GEN job that
    // is guaranteed to run first (pending now or arriving this cycle).
    peer_key_ok = priv_valid_reg || gen_full_reg || gen_accept;
    peer_accept = peer_req && !peer_full_reg && peer_pub_ok && peer_key_ok;
    peer_reject = peer_req && !peer_accept;

    take_gen    = (state_reg == IDLE) && gen_full_reg;
    take_peer   = (state_reg == IDLE) && !gen_full_reg && peer_full_reg;

    timeout_hit = (state_reg == WAIT) && !mp_rdy && (cnt_reg == TMO_LAST);
  end

  // Pending slots: filled by accepted requests in any state, emptied when
  // the FSM picks the job up. A full slot can never accept, so the fill and
  // the clear of one slot never happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_full_reg  <= 1'b0;
      gen_op_reg    <= '0;
      peer_full_reg <= 1'b0;
      peer_op_reg   <= '0;
    end else if (ena) begin
      if (gen_accept) begin
        gen_full_reg <= 1'b1;
        gen_op_reg   <= priv_key;
      end else if (take_gen) begin
        gen_full_reg <= 1'b0;
      end

      if (peer_accept) begin
        peer_full_reg <= 1'b1;
        peer_op_reg   <= peer_pub;
      end else if (take_peer) begin
        peer_full_reg <= 1'b0;
      end
    end
  end

  // Stored private key: replaced only when a GEN job is launched, so a
  // gen_req arriving mid-PEER-job cannot change that job's exponent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv_reg       <= '0;
      priv_valid_reg <= 1'b0;
    end else if (ena) begin
      if (take_gen) begin
        priv_reg       <= gen_op_reg;
        priv_valid_reg <= 1'b1;
      end
    end
  end

  // Job sequencer with registered engine controls, results and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      job_gen_reg  <= 1'b0;
      cnt_reg      <= '0;
      res_reg      <= '0;
      mp_start     <= 1'b0;
      mp_base      <= '0;
      mp_exp       <= '0;
      pub_key      <= '0;
      pub_valid    <= 1'b0;
      shared_key   <= '0;
      shared_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else if (ena) begin
      mp_start     <= 1'b0;
      pub_valid    <= 1'b0;
      shared_valid <= 1'b0;
      err          <= gen_reject || peer_reject || timeout_hit;

      case (state_reg)
        IDLE: begin
          if (take_gen) begin
            state_reg   <= ISSUE;
            job_gen_reg <= 1'b1;
            mp_start    <= 1'b1;
            mp_base     <= G_VAL;
            mp_exp      <= gen_op_reg;
            busy        <= 1'b1;
          end else if (take_peer) begin
            state_reg   <= ISSUE;
            job_gen_reg <= 1'b0;
            mp_start    <= 1'b1;
            mp_base     <= peer_op_reg;
            mp_exp      <= priv_reg;
            busy        <= 1'b1;
          end
        end

        ISSUE: begin
          // mp_start was raised on entry and drops on the way out.
          state_reg <= WAIT;
          cnt_reg   <= '0;
        end

        WAIT: begin
          if (mp_rdy) begin
            res_reg   <= mp_res;
            state_reg <= STORE;
          end else if (timeout_hit) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        STORE: begin
          if (job_gen_reg) begin
            pub_key   <= res_reg;
            pub_valid <= 1'b1;
          end else begin
            shared_key   <= res_reg;
            shared_valid <= 1'b1;
          end
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dh_key_sequencer.sv
// tb_dh_key_sequencer
// Directed bench for dh_key_sequencer with a behavioural modular-power engine
// whose latency can be set and whose answer can be withheld.
`timescale 1ns/1ps
module tb_dh_key_sequencer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b1;
  logic         gen_req = 1'b0;
  logic [N-1:0] priv_key = '0;
  logic         peer_req = 1'b0;
  logic [N-1:0] peer_pub = '0;
  logic         mp_start;
  logic [N-1:0] mp_base;
  logic [N-1:0] mp_exp;
  logic [N-1:0] mp_res = '0;
  logic         mp_rdy = 1'b0;
  logic [N-1:0] pub_key;
  logic         pub_valid;
  logic [N-1:0] shared_key;
  logic         shared_valid;
  logic         busy;
  logic         err;

  int tests = 0;
  int fails = 0;

  dh_key_sequencer #(.N(N), .P(89), .G(3), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .gen_req      (gen_req),
    .priv_key     (priv_key),
    .peer_req     (peer_req),
    .peer_pub     (peer_pub),
    .mp_start     (mp_start),
    .mp_base      (mp_base),
    .mp_exp       (mp_exp),
    .mp_res       (mp_res),
    .mp_rdy       (mp_rdy),
    .pub_key      (pub_key),
    .pub_valid    (pub_valid),
    .shared_key   (shared_key),
    .shared_valid (shared_valid),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Engine model and event counters, evaluated on the falling edge.
  int           eng_lat  = 3;
  bit           eng_hold = 1'b0;
  int           eng_cnt  = 0;
  logic [N-1:0] eng_b    = '0;
  logic [N-1:0] eng_e    = '0;
  logic [N-1:0] last_base = '0;
  logic [N-1:0] last_exp  = '0;
  int           start_cnt = 0;
  int           pv_cnt    = 0;
  int           sv_cnt    = 0;
  int           err_cnt   = 0;

  function automatic logic [N-1:0] modpow(input logic [N-1:0] b, input logic [N-1:0] e);
    int r;
    r = 1;
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % 89;
    return r[N-1:0];
  endfunction

  always @(negedge clk) begin
    mp_rdy = 1'b0;
    if (pub_valid)    pv_cnt++;
    if (shared_valid) sv_cnt++;
    if (err)          err_cnt++;
    if (mp_start) begin
      start_cnt++;
      last_base = mp_base;
      last_exp  = mp_exp;
      eng_b     = mp_base;
      eng_e     = mp_exp;
      eng_cnt   = eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !eng_hold) begin
        mp_rdy = 1'b1;
        mp_res = modpow(eng_b, eng_e);
      end
    end
  end

  task automatic check8(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic pulse_gen(input logic [N-1:0] k);
    gen_req  = 1'b1;
    priv_key = k;
    step(1);
    gen_req  = 1'b0;
    $display("[TB] gen_req priv_key=%0d err=%0b", k, err);
  endtask

  task automatic pulse_peer(input logic [N-1:0] p);
    peer_req = 1'b1;
    peer_pub = p;
    step(1);
    peer_req = 1'b0;
    $display("[TB] peer_req peer_pub=%0d err=%0b", p, err);
  endtask

  task automatic wait_pub(output int cyc);
    cyc = 0;
    while (!pub_valid && cyc < 200) begin
      step(1);
      cyc++;
    end
    $display("[TB] pub_valid after %0d cycles pub_key=%0d", cyc, pub_key);
  endtask

  task automatic wait_shared(output int cyc);
    cyc = 0;
    while (!shared_valid && cyc < 200) begin
      step(1);
      cyc++;
    end
    $display("[TB] shared_valid after %0d cycles shared_key=%0d", cyc, shared_key);
  endtask

  task automatic wait_err(output int cyc);
    cyc = 0;
    while (!err && cyc < 200) begin
      step(1);
      cyc++;
    end
    $display("[TB] err after %0d cycles busy=%0b", cyc, busy);
  endtask

  initial begin
    int cyc;
    int s0, e0, p0, q0;

    // Reset state.
    rst = 1'b1;
    step(3);
    check1("rst_busy", busy, 1'b0);
    check1("rst_start", mp_start, 1'b0);
    check8("rst_pub", pub_key, 8'd0);
    check8("rst_shared", shared_key, 8'd0);
    check8("rst_base", mp_base, 8'd0);
    check1("rst_err", err, 1'b0);
    rst = 1'b0;
    step(1);

    // GEN with key 5: engine sees (3,5), result 65 after latency + 3.
    s0 = start_cnt; e0 = err_cnt;
    pulse_gen(8'd5);
    wait_pub(cyc);
    checki("gen_latency", cyc, 6);
    check8("gen_pub", pub_key, 8'd65);
    check8("gen_base", last_base, 8'd3);
    check8("gen_exp", last_exp, 8'd5);
    checki("gen_starts", start_cnt - s0, 1);
    step(1);
    check1("pub_valid_pulse", pub_valid, 1'b0);
    checki("gen_no_err", err_cnt - e0, 0);

    // PEER with 10: engine sees (10,5), shared 53.
    s0 = start_cnt;
    pulse_peer(8'd10);
    wait_shared(cyc);
    checki("peer_latency", cyc, 6);
    check8("peer_shared", shared_key, 8'd53);
    check8("peer_base", last_base, 8'd10);
    check8("peer_exp", last_exp, 8'd5);
    checki("peer_starts", start_cnt - s0, 1);
    step(1);
    check1("idle_busy", busy, 1'b0);

    // Same-cycle GEN and PEER from reset: GEN first, then PEER, no err.
    do_reset();
    s0 = start_cnt; e0 = err_cnt; q0 = sv_cnt;
    gen_req = 1'b1; priv_key = 8'd5;
    peer_req = 1'b1; peer_pub = 8'd10;
    step(1);
    gen_req = 1'b0; peer_req = 1'b0;
    $display("[TB] gen_req+peer_req priv_key=5 peer_pub=10 err=%0b", err);
    wait_pub(cyc);
    check8("both_pub", pub_key, 8'd65);
    checki("both_shared_later", sv_cnt - q0, 0);
    wait_shared(cyc);
    check8("both_shared", shared_key, 8'd53);
    checki("both_no_err", err_cnt - e0, 0);
    checki("both_starts", start_cnt - s0, 2);

    // Rejected PEER requests: no key yet, then out-of-range values.
    do_reset();
    s0 = start_cnt;
    pulse_peer(8'd10);
    check1("peer_nokey_err", err, 1'b1);
    step(1);
    check1("err_pulse", err, 1'b0);
    step(4);
    checki("peer_nokey_nostart", start_cnt - s0, 0);
    pulse_gen(8'd5);
    wait_pub(cyc);
    check8("rekey_pub", pub_key, 8'd65);
    step(1);
    s0 = start_cnt;
    pulse_peer(8'd89);
    check1("peer_89_err", err, 1'b1);
    pulse_peer(8'd1);
    check1("peer_1_err", err, 1'b1);
    pulse_peer(8'd0);
    check1("peer_0_err", err, 1'b1);
    step(4);
    checki("peer_bad_nostart", start_cnt - s0, 0);
    check1("peer_bad_busy", busy, 1'b0);

    // Bad GEN keys.
    pulse_gen(8'h80);
    check1("gen_80_err", err, 1'b1);
    pulse_gen(8'h00);
    check1("gen_0_err", err, 1'b1);
    step(4);
    checki("gen_bad_nostart", start_cnt - s0, 0);

    // ena low: requests are not latched.
    ena = 1'b0;
    pulse_gen(8'd7);
    ena = 1'b1;
    step(4);
    checki("ena_low_nostart", start_cnt - s0, 0);

    // Full slot drop and exponent isolation during a PEER job.
    eng_lat = 10;
    pulse_peer(8'd10);
    step(3);
    pulse_gen(8'd7);
    pulse_gen(8'd9);
    check1("slot_full_err", err, 1'b1);
    wait_shared(cyc);
    check8("iso_shared", shared_key, 8'd53);
    check8("iso_exp", last_exp, 8'd5);
    wait_pub(cyc);
    check8("slot_pub", pub_key, 8'd51);
    check8("slot_exp", last_exp, 8'd7);
    eng_lat = 3;
    step(2);

    // Engine timeout: err after 1 latch + ISSUE + 64 WAIT cycles.
    eng_hold = 1'b1;
    p0 = pv_cnt;
    pulse_gen(8'd5);
    wait_err(cyc);
    checki("timeout_cycles", cyc, 66);
    check1("timeout_busy", busy, 1'b0);
    checki("timeout_no_pub", pv_cnt - p0, 0);
    eng_hold = 1'b0;
    step(2);

    // Reset mid-WAIT: outputs clear at once, a late mp_rdy is ignored.
    eng_lat = 8;
    pulse_gen(8'd5);
    step(3);
    check1("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check1("async_busy", busy, 1'b0);
    check8("async_base", mp_base, 8'd0);
    check8("async_exp", mp_exp, 8'd0);
    check8("async_pub", pub_key, 8'd0);
    step(2);
    rst = 1'b0;
    p0 = pv_cnt;
    step(12);
    checki("late_rdy_no_pub", pv_cnt - p0, 0);
    check8("late_rdy_pub", pub_key, 8'd0);
    check1("late_rdy_busy", busy, 1'b0);
    eng_lat = 3;
    pulse_gen(8'd5);
    wait_pub(cyc);
    check8("post_rst_pub", pub_key, 8'd65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
